bram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 64 KiB MCU BRAM between the instruction-fetch unit and the load/store unit. It serializes requests, drives the BRAM read/write strobes, returns read data with a per-requester acknowledge, and rejects misaligned word accesses. It sits between the core's fetch/LSU ports and the BRAM instance.

---
 rtl/bram_arb_pkg.sv | 24 ++
 rtl/bram_arbiter_if.sv | 51 +++++
 rtl/bram_arb_pick.sv | 32 +++
 rtl/bram_arbiter.sv | 126 ++++++++++++
 tb/tb_bram_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM arbiter: FSM states, requester IDs, widths.
// Used by bram_arbiter, bram_arb_pick and bram_arbiter_if.
package bram_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        if (id == REQ_DATA) return REQ_FETCH;
        return REQ_DATA;
    endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Fetch / load-store / BRAM bus bundle of the BRAM arbiter.
// slave = arbiter side, master = core + BRAM side.
interface bram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              bram_rd_en;
    logic              bram_wr_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_idata;
    logic [DATA_W-1:0] bram_odata;

    logic              busy;

    modport slave (
        input  f_req, f_addr,
        output f_ack, f_rdata, f_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata, d_err,
        output bram_rd_en, bram_wr_en,
        output bram_addr, bram_idata,
        input  bram_odata,
        output busy
    );

    modport master (
        output f_req, f_addr,
        input  f_ack, f_rdata, f_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  bram_rd_en, bram_wr_en,
        input  bram_addr, bram_idata,
        output bram_odata,
        input  busy
    );

endinterface

// File: rtl/bram_arb_pick.sv
// Winner selection between fetch and data requests.
// Masked requesters are excluded; prio_i breaks a tie.
module bram_arb_pick
    import bram_arb_pkg::*;
(
    input  logic    f_req_i,
    input  logic    d_req_i,
    input  logic    mask_f_i,
    input  logic    mask_d_i,
    input  req_id_t prio_i,
    output logic    valid_o,
    output req_id_t win_o
);

    logic cand_f;
    logic cand_d;

    assign cand_f = f_req_i & ~mask_f_i;
    assign cand_d = d_req_i & ~mask_d_i;

    // Sole candidate wins; a tie goes to prio_i.
    always_comb begin
        valid_o = cand_f | cand_d;
        win_o   = prio_i;
        unique case (1'b1)
            (cand_f & ~cand_d): win_o = REQ_FETCH;
            (cand_d & ~cand_f): win_o = REQ_DATA;
            default:            win_o = prio_i;
        endcase
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between instruction fetch and LSU.
// Define BRAM_ARB_RR_EN for round-robin ties; default is data-first.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic          clk,
    input logic          rst,
    bram_arbiter_if.slave bus
);

    state_t            state_q;
    req_id_t           owner_q;
    logic              we_q;
    logic              err_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] idata_q;
    req_id_t           prio_q;

    logic              gnt_valid;
    req_id_t           gnt_id;
    logic              grant_d;
    logic              we_d;
    logic              mis_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] idata_d;

    logic in_resp;
    logic own_f;
    logic own_d;

    assign in_resp = (state_q == RESP);
    assign own_f   = (owner_q == REQ_FETCH);
    assign own_d   = (owner_q == REQ_DATA);

    bram_arb_pick u_pick (
        .f_req_i  (bus.f_req),
        .d_req_i  (bus.d_req),
        .mask_f_i (in_resp & own_f),
        .mask_d_i (in_resp & own_d),
        .prio_i   (prio_q),
        .valid_o  (gnt_valid),
        .win_o    (gnt_id)
    );

    assign grant_d = gnt_valid & (state_q != ISSUE);
    assign we_d    = (gnt_id == REQ_DATA) & bus.d_we;
    assign addr_d  = (gnt_id == REQ_DATA) ? bus.d_addr : bus.f_addr;
    assign mis_d   = |addr_d[1:0];
    assign idata_d = (gnt_id == REQ_DATA) ? bus.d_wdata : '0;

`ifdef BRAM_ARB_RR_EN
    // Tie priority goes to whoever was not granted last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= REQ_DATA;
        end else if (grant_d) begin
            prio_q <= other_req(gnt_id);
        end
    end
`else
    assign prio_q = REQ_DATA;
`endif

    // Arbiter FSM with registered BRAM strobes, address and write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= REQ_DATA;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            idata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (grant_d) begin
                        state_q <= ISSUE;
                        owner_q <= gnt_id;
                        we_q    <= we_d;
                        err_q   <= mis_d;
                        rd_q    <= ~we_d & ~mis_d;
                        wr_q    <= we_d & ~mis_d;
                        addr_q  <= addr_d;
                        idata_q <= idata_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    state_q <= RESP;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    logic rd_ok;
    assign rd_ok = in_resp & ~we_q & ~err_q;

    assign bus.f_ack   = in_resp & own_f;
    assign bus.d_ack   = in_resp & own_d;
    assign bus.f_err   = in_resp & own_f & err_q;
    assign bus.d_err   = in_resp & own_d & err_q;
    assign bus.f_rdata = (rd_ok & own_f) ? bus.bram_odata : '0;
    assign bus.d_rdata = (rd_ok & own_d) ? bus.bram_odata : '0;

    assign bus.bram_rd_en = rd_q;
    assign bus.bram_wr_en = wr_q;
    assign bus.bram_addr  = addr_q;
    assign bus.bram_idata = idata_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter.
// Includes a small registered-read BRAM model.
module tb_bram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    bram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] odata = 32'h0;

    always @(posedge clk) begin
        if (bus.bram_wr_en) mem[bus.bram_addr[9:2]] <= bus.bram_idata;
        if (bus.bram_rd_en) odata <= mem[bus.bram_addr[9:2]];
    end

    assign bus.bram_odata = odata;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int n_f, n_d, n_both, n_alt_bad;
    logic last_d;
    logic have_last;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        bus.f_req   = 1'b0;
        bus.f_addr  = 16'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0;
        bus.d_wdata = 32'h0;

        // Reset state
        cyc();
        cyc();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rd", 32'(bus.bram_rd_en), 32'd0);
        chk("rst_addr", 32'(bus.bram_addr), 32'd0);
        chk("rst_ack", 32'({bus.f_ack, bus.d_ack}), 32'd0);
        rst = 1'b0;
        cyc();

        // Reset asserted mid-ISSUE
        bus.d_req  = 1'b1;
        bus.d_addr = 16'h0010;
        cyc();
        chk("mid_rd_before", 32'(bus.bram_rd_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rd_drop", 32'(bus.bram_rd_en), 32'd0);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        bus.d_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("mid_noack", 32'(bus.d_ack), 32'd0);
        chk("mid_busy_after", 32'(bus.busy), 32'd0);

        // Single fetch read of word 4
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0010;
        cyc();
        chk("f_rd_en", 32'(bus.bram_rd_en), 32'd1);
        chk("f_noack_issue", 32'(bus.f_ack), 32'd0);
        chk("f_busy", 32'(bus.busy), 32'd1);
        cyc();
        chk("f_ack", 32'(bus.f_ack), 32'd1);
        chk("f_rdata", bus.f_rdata, 32'hDEADBEEF);
        chk("f_err", 32'(bus.f_err), 32'd0);
        chk("f_rd_off", 32'(bus.bram_rd_en), 32'd0);
        bus.f_req = 1'b0;
        cyc();
        chk("f_ack_off", 32'(bus.f_ack), 32'd0);
        chk("f_idle", 32'(bus.busy), 32'd0);

        // Data write then fetch read of the same word, back to back
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0020;
        bus.d_wdata = 32'h55AA00FF;
        cyc();
        chk("w_wr_en", 32'(bus.bram_wr_en), 32'd1);
        chk("w_rd_en", 32'(bus.bram_rd_en), 32'd0);
        chk("w_addr", 32'(bus.bram_addr), 32'h20);
        chk("w_idata", bus.bram_idata, 32'h55AA00FF);
        cyc();
        chk("w_ack", 32'(bus.d_ack), 32'd1);
        chk("w_rdata", bus.d_rdata, 32'd0);
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0020;
        cyc();
        chk("wr_f_rd_en", 32'(bus.bram_rd_en), 32'd1);
        cyc();
        chk("wr_f_ack", 32'(bus.f_ack), 32'd1);
        chk("wr_f_rdata", bus.f_rdata, 32'h55AA00FF);
        bus.f_req = 1'b0;
        cyc();

        // Simultaneous requests from IDLE: data first, then fetch
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0010;
        bus.d_req  = 1'b1;
        bus.d_addr = 16'h0020;
        cyc();
        chk("sim_issue_addr", 32'(bus.bram_addr), 32'h20);
        cyc();
        chk("sim_d_ack", 32'(bus.d_ack), 32'd1);
        chk("sim_f_wait", 32'(bus.f_ack), 32'd0);
        chk("sim_d_rdata", bus.d_rdata, 32'h55AA00FF);
        bus.d_req = 1'b0;
        cyc();
        chk("sim_f_issue", 32'(bus.bram_addr), 32'h10);
        cyc();
        chk("sim_f_ack", 32'(bus.f_ack), 32'd1);
        chk("sim_f_rdata", bus.f_rdata, 32'hDEADBEEF);
        bus.f_req = 1'b0;
        cyc();

        // Misaligned data read
        bus.d_req  = 1'b1;
        bus.d_addr = 16'h0003;
        cyc();
        chk("mis_strobes", 32'({bus.bram_rd_en, bus.bram_wr_en}), 32'd0);
        cyc();
        chk("mis_ack", 32'(bus.d_ack), 32'd1);
        chk("mis_err", 32'(bus.d_err), 32'd1);
        chk("mis_rdata", bus.d_rdata, 32'd0);
        bus.d_req = 1'b0;
        cyc();

        // Both held for 20 cycles
        n_f = 0; n_d = 0; n_both = 0; n_alt_bad = 0;
        have_last = 1'b0;
        last_d = 1'b0;
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0010;
        bus.d_req  = 1'b1;
        bus.d_addr = 16'h0020;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.f_ack) n_f++;
            if (bus.d_ack) n_d++;
            if (bus.f_ack && bus.d_ack) n_both++;
            if (bus.f_ack ^ bus.d_ack) begin
                if (have_last && (last_d == bus.d_ack)) n_alt_bad++;
                last_d = bus.d_ack;
                have_last = 1'b1;
            end
        end
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        chk("hold_acks", 32'(n_f + n_d), 32'd10);
        chk("hold_f_acks", 32'(n_f), 32'd5);
        chk("hold_both", 32'(n_both), 32'd0);
        chk("hold_alt", 32'(n_alt_bad), 32'd0);
        cyc();
        cyc();
        chk("end_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
